// File: rtl/pe2_layer_ctrl_pkg.sv
// Shared types and defaults for the layer-2 sequencer: state encoding, dimensions
// and the kernel-tap one-hot helper.
package pe2_layer_ctrl_pkg;

  localparam int unsigned OUT_DIM_D = 10;
  localparam int unsigned TAPS_D    = 16;
  localparam int unsigned NPE_D     = 4;
  localparam int unsigned KW        = 16;
  localparam int unsigned ROW_W     = 4;
  localparam int unsigned WIN_W     = 7;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_KLOAD = 3'd1;
  localparam state_t S_PLOAD = 3'd2;
  localparam state_t S_WLOAD = 3'd3;
  localparam state_t S_MAC   = 3'd4;
  localparam state_t S_WRITE = 3'd5;
  localparam state_t S_ADV   = 3'd6;
  localparam state_t S_DONE  = 3'd7;

  // One-hot tap strobe for one PE; replicated across PEs by the caller.
  function automatic logic [KW-1:0] tap_onehot(input logic [3:0] k);
    logic [KW-1:0] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/pe2_layer_ctrl_if.sv
// Control bundle between the layer-2 sequencer (master) and the PE2 datapath (slave).
interface pe2_layer_ctrl_if
  import pe2_layer_ctrl_pkg::*;
#(
  parameter int unsigned NPE = NPE_D
) ();

  logic              start;
  logic              cout_adr_buf13;
  logic              count_max_cout;
  logic              busy;
  logic              done2;
  logic [NPE*KW-1:0] kernel_filter2_en;
  logic              buf13x13_we;
  logic              shift_buf13x13;
  logic              rst_adr_buf13;
  logic              en_adr_buf13;
  logic [KW-1:0]     buf4x4_en;
  logic              count_max_rst;
  logic              count_max_en;
  logic              PE2_mac_rst;
  logic              PE2_mac_en;
  logic              PE2_sh_reg_en;
  logic              PE_counter_rst;
  logic              PE2_counter_en;
  logic              OFM_wr;
  logic [31:0]       OFM_adr_in;

  modport master (
    input  start, cout_adr_buf13, count_max_cout,
    output busy, done2, kernel_filter2_en, buf13x13_we, shift_buf13x13,
           rst_adr_buf13, en_adr_buf13, buf4x4_en, count_max_rst, count_max_en,
           PE2_mac_rst, PE2_mac_en, PE2_sh_reg_en, PE_counter_rst, PE2_counter_en,
           OFM_wr, OFM_adr_in
  );

  modport slave (
    output start, cout_adr_buf13, count_max_cout,
    input  busy, done2, kernel_filter2_en, buf13x13_we, shift_buf13x13,
           rst_adr_buf13, en_adr_buf13, buf4x4_en, count_max_rst, count_max_en,
           PE2_mac_rst, PE2_mac_en, PE2_sh_reg_en, PE_counter_rst, PE2_counter_en,
           OFM_wr, OFM_adr_in
  );

endinterface

// File: rtl/pe2_layer_ctrl_win_pos.sv
// Window position tracker: output row counter and linear window index.
module pe2_win_pos
  import pe2_layer_ctrl_pkg::*;
#(
  parameter int unsigned OUT_DIM = OUT_DIM_D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_row_inc,
  input  logic             i_win_inc,
  output logic [WIN_W-1:0] o_win,
  output logic             o_last_row
);

  logic [ROW_W-1:0] r_row;
  logic [WIN_W-1:0] r_win;

  always_ff @(posedge clk) begin
    if (!rst || i_clr) begin
      r_row <= '0;
      r_win <= '0;
    end else begin
      if (i_row_inc) r_row <= r_row + ROW_W'(1);
      if (i_win_inc) r_win <= r_win + WIN_W'(1);
    end
  end

  assign o_win      = r_win;
  assign o_last_row = (r_row == ROW_W'(OUT_DIM - 1));

endmodule

// File: rtl/pe2_layer_ctrl.sv
// Layer-2 sequencer: loads PE2 kernels, latches the 13x13 maps and sweeps a 4x4
// window over all output positions, one MAC pass and one OFM write per window.
module pe2_layer_ctrl
  import pe2_layer_ctrl_pkg::*;
#(
  parameter int unsigned OUT_DIM  = OUT_DIM_D,
  parameter int unsigned TAPS     = TAPS_D,
  parameter int unsigned NPE      = NPE_D,
  parameter logic [31:0] OFM_BASE = 32'd0
) (
  input logic              clk,
  input logic              rst,
  pe2_layer_ctrl_if.master bus
);

  state_t            r_state, w_next;
  logic [3:0]        r_k, w_k_next;
  logic              w_clr, w_row_inc, w_win_inc, w_last_row, w_wrap;
  logic [WIN_W-1:0]  w_win;
  logic [NPE*KW-1:0] r_kernel;
  logic [KW-1:0]     r_buf4_en;
  logic              r_busy, r_done2, r_pload, r_mac_rst, r_mac, r_write, r_adv;
  logic [31:0]       r_ofm_adr;

  pe2_win_pos #(.OUT_DIM(OUT_DIM)) u_win_pos (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_clr),
    .i_row_inc  (w_row_inc),
    .i_win_inc  (w_win_inc),
    .o_win      (w_win),
    .o_last_row (w_last_row)
  );

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_clr     = 1'b0;
    w_row_inc = 1'b0;
    w_win_inc = 1'b0;
    w_k_next  = r_k;
    case (r_state)
      S_IDLE: if (bus.start) begin
        w_next   = S_KLOAD;
        w_clr    = 1'b1;
        w_k_next = 4'd0;
      end
      S_KLOAD: begin
        w_k_next = r_k + 4'd1;
        if (r_k == 4'(TAPS - 1)) w_next = S_PLOAD;
      end
      S_PLOAD: w_next = S_WLOAD;
      S_WLOAD: w_next = S_MAC;
      S_MAC:   if (bus.count_max_cout) w_next = S_WRITE;
      S_WRITE: begin
        w_win_inc = 1'b1;
        w_next    = S_ADV;
      end
      S_ADV: begin
        if (!bus.cout_adr_buf13) begin
          w_next = S_WLOAD;
        end else if (w_last_row) begin
          w_next = S_DONE;
        end else begin
          w_row_inc = 1'b1;
          w_next    = S_WLOAD;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_k       <= '0;
      r_kernel  <= '0;
      r_buf4_en <= '0;
      r_busy    <= 1'b0;
      r_done2   <= 1'b0;
      r_pload   <= 1'b0;
      r_mac_rst <= 1'b0;
      r_mac     <= 1'b0;
      r_write   <= 1'b0;
      r_adv     <= 1'b0;
      r_ofm_adr <= OFM_BASE;
    end else begin
      r_k       <= w_k_next;
      r_kernel  <= (w_next == S_KLOAD) ? {NPE{tap_onehot(w_k_next)}} : '0;
      r_buf4_en <= {KW{w_next == S_WLOAD}};
      r_busy    <= (w_next != S_IDLE);
      r_done2   <= (w_next == S_DONE);
      r_pload   <= (w_next == S_PLOAD);
      // PE2 shift register samples the accumulator on the same edge the MAC clears.
      r_mac_rst <= (w_next == S_PLOAD) || (w_next == S_WRITE);
      r_mac     <= (w_next == S_MAC);
      r_write   <= (w_next == S_WRITE);
      r_adv     <= (w_next == S_ADV);
      if (w_clr)                  r_ofm_adr <= OFM_BASE;
      else if (w_next == S_WRITE) r_ofm_adr <= OFM_BASE + 32'(w_win);
    end
  end

  // ADV strobes follow the live column flag, matching the branch taken this cycle.
  assign w_wrap = r_adv & bus.cout_adr_buf13 & ~w_last_row;

  assign bus.busy              = r_busy;
  assign bus.done2             = r_done2;
  assign bus.kernel_filter2_en = r_kernel;
  assign bus.buf13x13_we       = r_pload;
  assign bus.shift_buf13x13    = w_wrap;
  assign bus.rst_adr_buf13     = r_pload | w_wrap;
  assign bus.en_adr_buf13      = r_adv & ~bus.cout_adr_buf13;
  assign bus.buf4x4_en         = r_buf4_en;
  assign bus.count_max_rst     = r_pload;
  assign bus.count_max_en      = r_mac;
  assign bus.PE2_mac_rst       = r_mac_rst;
  assign bus.PE2_mac_en        = r_mac;
  assign bus.PE2_sh_reg_en     = r_write;
  assign bus.PE_counter_rst    = r_pload;
  assign bus.PE2_counter_en    = r_write;
  assign bus.OFM_wr            = r_write;
  assign bus.OFM_adr_in        = r_ofm_adr;

  // A tap counter already at its maximum on the first MAC cycle indicates a counter fault.
  a_tap_fault: assert property (@(posedge clk) disable iff (!rst)
    (r_state == S_MAC && $past(r_state) == S_WLOAD) |-> !bus.count_max_cout);

endmodule
